// File: rtl/pem_dispatch.sv
// pem_dispatch: memory-DOP dispatcher between the scheduler and pe_mem.
//
// Holds one output register stage toward pe_mem, tracks outstanding loads and
// stores with occupancy counters, and registers the completion acks back to
// the scheduler.
//
// DOP layout on inst / pem_inst (pem_inst_t, MSB first):
//   dop [PE_INST_W-1 -: 8] | rid [next 12 bits] | cid [remaining low bits]
// The register index is rid[REGF_REGID_W-1:0].
//
// Optional feature: define PEM_DISPATCH_HAZARD_CHECK_EN to build the regid
// FIFOs and the WAR/RAW hazard check. Without it only the counters and the
// count limits exist and hazard_stall is tied low.
//
// A DOP sitting in the output stage already counts toward its type's limit,
// so the regid FIFOs can never be pushed beyond OUTSTD_DEPTH entries.
module pem_dispatch #(
    parameter int         OUTSTD_DEPTH = 4,
    parameter int         PE_INST_W    = 32,
    parameter int         REGF_REGID_W = 5,
    parameter logic [7:0] DOP_LD       = 8'h01
) (
    input  logic                                 clk,
    input  logic                                 s_rst_n,
    input  logic [PE_INST_W-1:0]                 inst,
    input  logic                                 inst_vld,
    output logic                                 inst_rdy,
    output logic [PE_INST_W-1:0]                 pem_inst,
    output logic                                 pem_inst_vld,
    input  logic                                 pem_inst_rdy,
    input  logic                                 pem_ld_ack,
    input  logic                                 pem_st_ack,
    output logic                                 ld_ack,
    output logic                                 st_ack,
    output logic [$clog2(OUTSTD_DEPTH+1)-1:0]    ld_outstd,
    output logic [$clog2(OUTSTD_DEPTH+1)-1:0]    st_outstd,
    output logic                                 hazard_stall
);

    localparam int DOP_W = 8;
    localparam int RID_W = 12;
    localparam int CID_W = PE_INST_W - DOP_W - RID_W;
    localparam int CNT_W = $clog2(OUTSTD_DEPTH + 1);

    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(OUTSTD_DEPTH);

    // ------------------------------------------------------------------
    // Output stage and counters
    // ------------------------------------------------------------------
    logic [PE_INST_W-1:0] out_data;
    logic                 out_vld;
    logic [CNT_W-1:0]     ld_cnt;
    logic [CNT_W-1:0]     st_cnt;

    logic in_is_ld;
    logic out_is_ld;
    logic hazard;
    logic ld_full;
    logic st_full;
    logic blocked;
    logic accept;
    logic pem_hs;
    logic ld_push;
    logic st_push;
    logic ld_pop;
    logic st_pop;

    logic [CNT_W:0] ld_occ;
    logic [CNT_W:0] st_occ;

    assign in_is_ld  = (inst[PE_INST_W-1 -: DOP_W] == DOP_LD);
    assign out_is_ld = (out_data[PE_INST_W-1 -: DOP_W] == DOP_LD);

    // Occupancy seen by the limit check includes a DOP parked in the output stage.
    assign ld_occ  = {1'b0, ld_cnt} + {{CNT_W{1'b0}}, (out_vld &  out_is_ld)};
    assign st_occ  = {1'b0, st_cnt} + {{CNT_W{1'b0}}, (out_vld & ~out_is_ld)};
    assign ld_full = (ld_occ >= DEPTH_LIM);
    assign st_full = (st_occ >= DEPTH_LIM);

    assign blocked  = (in_is_ld ? ld_full : st_full) | hazard;
    assign inst_rdy = s_rst_n & (~out_vld | pem_inst_rdy) & ~blocked;
    assign accept   = inst_vld & inst_rdy;

    assign pem_hs  = out_vld & pem_inst_rdy;
    assign ld_push = pem_hs &  out_is_ld;
    assign st_push = pem_hs & ~out_is_ld;

    // Acks with nothing outstanding are dropped so the counters never wrap.
    assign ld_pop = pem_ld_ack & (ld_cnt != '0);
    assign st_pop = pem_st_ack & (st_cnt != '0);

    assign pem_inst     = out_data;
    assign pem_inst_vld = out_vld;
    assign ld_outstd    = ld_cnt;
    assign st_outstd    = st_cnt;
    assign hazard_stall = s_rst_n & inst_vld & hazard;

    // Output stage valid: load on accept, drain on downstream handshake.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            out_vld <= 1'b0;
        end else if (accept) begin
            out_vld <= 1'b1;
        end else if (pem_inst_rdy) begin
            out_vld <= 1'b0;
        end
    end

    // Output stage data is not reset; it only changes on an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            out_data <= inst;
        end
    end

    // Outstanding counters: push on pe_mem handshake, pop on the matching ack.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            ld_cnt <= '0;
            st_cnt <= '0;
        end else begin
            ld_cnt <= ld_cnt + CNT_W'(ld_push) - CNT_W'(ld_pop);
            st_cnt <= st_cnt + CNT_W'(st_push) - CNT_W'(st_pop);
        end
    end

    // Acks to the scheduler are one-cycle-delayed copies of the pe_mem pulses.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            ld_ack <= 1'b0;
            st_ack <= 1'b0;
        end else begin
            ld_ack <= pem_ld_ack;
            st_ack <= pem_st_ack;
        end
    end

`ifdef PEM_DISPATCH_HAZARD_CHECK_EN
    // ------------------------------------------------------------------
    // Regid FIFOs and hazard detection
    // ------------------------------------------------------------------
    // Entry 0 is the oldest; valid entries are indices below the counter.
    logic [REGF_REGID_W-1:0] ld_fifo [OUTSTD_DEPTH];
    logic [REGF_REGID_W-1:0] st_fifo [OUTSTD_DEPTH];

    logic [REGF_REGID_W-1:0] in_reg;
    logic [REGF_REGID_W-1:0] out_reg;
    logic [CNT_W-1:0]        ld_wr_idx;
    logic [CNT_W-1:0]        st_wr_idx;
    logic                    raw_hit;
    logic                    war_hit;

    assign in_reg    = inst[CID_W +: REGF_REGID_W];
    assign out_reg   = out_data[CID_W +: REGF_REGID_W];
    assign ld_wr_idx = ld_cnt - CNT_W'(ld_pop);
    assign st_wr_idx = st_cnt - CNT_W'(st_pop);

    // Search outstanding loads (RAW) and stores (WAR), plus the output stage.
    always_comb begin
        raw_hit = 1'b0;
        war_hit = 1'b0;
        for (int i = 0; i < OUTSTD_DEPTH; i++) begin
            if ((CNT_W'(i) < ld_cnt) && (ld_fifo[i] == in_reg)) raw_hit = 1'b1;
            if ((CNT_W'(i) < st_cnt) && (st_fifo[i] == in_reg)) war_hit = 1'b1;
        end
        if (out_vld && (out_reg == in_reg)) begin
            if (out_is_ld) raw_hit = 1'b1;
            else           war_hit = 1'b1;
        end
    end

    // A load waits on stores reading the same reg; a store waits on loads writing it.
    assign hazard = in_is_ld ? war_hit : raw_hit;

    // Shift-out on pop, write behind the last valid entry on push.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            for (int i = 0; i < OUTSTD_DEPTH; i++) begin
                ld_fifo[i] <= '0;
                st_fifo[i] <= '0;
            end
        end else begin
            if (ld_pop) begin
                for (int i = 0; i < OUTSTD_DEPTH - 1; i++) ld_fifo[i] <= ld_fifo[i+1];
            end
            if (st_pop) begin
                for (int i = 0; i < OUTSTD_DEPTH - 1; i++) st_fifo[i] <= st_fifo[i+1];
            end
            if (ld_push) begin
                for (int i = 0; i < OUTSTD_DEPTH; i++) begin
                    if (CNT_W'(i) == ld_wr_idx) ld_fifo[i] <= out_reg;
                end
            end
            if (st_push) begin
                for (int i = 0; i < OUTSTD_DEPTH; i++) begin
                    if (CNT_W'(i) == st_wr_idx) st_fifo[i] <= out_reg;
                end
            end
        end
    end
`else
    assign hazard = 1'b0;
`endif

`ifndef SYNTHESIS
    // An ack with nothing outstanding is a pe_mem protocol error.
    always @(posedge clk) begin
        if (s_rst_n && pem_ld_ack && (ld_cnt == '0)) $fatal(1, "pem_dispatch: pem_ld_ack with no outstanding load");
        if (s_rst_n && pem_st_ack && (st_cnt == '0)) $fatal(1, "pem_dispatch: pem_st_ack with no outstanding store");
    end
`endif

endmodule

// File: doc/pem_dispatch.md
PEM_DISPATCH -- requirements
Module: pem_dispatch

Interface
REQ-001 SHALL have parameter OUTSTD_DEPTH, default 4, giving the maximum outstanding loads and the maximum outstanding stores (each tracked separately, range 1..16).
REQ-002 SHALL have port clk  input  1  clock; all logic is rising-edge.
REQ-003 SHALL have port s_rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port inst  input  PE_INST_W  memory DOP from the scheduler, decoded as pem_inst_t (dop, rid, cid).
REQ-005 SHALL have port inst_vld / inst_rdy  input / output  1 each  upstream valid/ready handshake.
REQ-006 SHALL have port pem_inst  output  PE_INST_W  DOP forwarded to pe_mem, unmodified.
REQ-007 SHALL have port pem_inst_vld / pem_inst_rdy  output / input  1 each  downstream valid/ready handshake.
REQ-008 SHALL have port pem_ld_ack / pem_st_ack  input  1 each  one-cycle completion pulses from pe_mem, each type in issue order.
REQ-009 SHALL have port ld_ack / st_ack  output  1 each  acks to the scheduler, registered copies of pem_ld_ack / pem_st_ack.
REQ-010 SHALL have port ld_outstd / st_outstd  output  $clog2(OUTSTD_DEPTH+1)  current outstanding counts.
REQ-011 SHALL have port hazard_stall  output  1  high while a valid DOP is held back by a hazard.

Function
REQ-012 SHALL classify a DOP as a load when dop==DOP_LD, otherwise as a store; the register index is rid[REGF_REGID_W-1:0].
REQ-013 SHALL hold one output register stage: an accepted DOP appears on pem_inst with pem_inst_vld=1 on the next cycle; pem_inst stays stable while pem_inst_vld=1 and pem_inst_rdy=0.
REQ-014 SHALL assert inst_rdy = (output stage empty, or pem_inst_rdy=1) AND no blocking condition; inst_rdy is combinational on inst.
REQ-015 SHALL treat these as blocking conditions: for a load, ld_outstd==OUTSTD_DEPTH; for a store, st_outstd==OUTSTD_DEPTH; any hazard per REQ-017.
REQ-016 SHALL keep two in-order regid FIFOs (load, store), each OUTSTD_DEPTH deep: push on pem_inst handshake, pop on the matching pem_*_ack; the counters equal the FIFO occupancies.
REQ-017 SHALL detect hazards. A load to R is blocked while any outstanding store reads R (WAR), including a store still in the output stage. A store from R is blocked while any outstanding load writes R (RAW), including a load still in the output stage.
REQ-018 SHALL evaluate the blocking conditions on registered state only: an ack arriving in cycle N unblocks from cycle N+1.
REQ-019 SHALL leave a counter unchanged when push and pop of the same type occur in the same cycle.
REQ-020 SHALL ignore an ack whose count is 0 (counter saturates at 0); simulation SHALL $fatal.
REQ-021 SHALL drive ld_ack/st_ack exactly one cycle after pem_ld_ack/pem_st_ack.
REQ-022 SHALL drive hazard_stall = inst_vld AND a REQ-017 hazard, independent of the count limits.

Reset
REQ-023 SHALL, while s_rst_n=0, clear both FIFOs and counters, the output stage valid, ld_ack, st_ack and hazard_stall. Output data is not reset.
REQ-024 SHALL discard an in-flight output-stage DOP on reset; late acks after reset fall under REQ-020.

Configuration
REQ-025 SHALL compile the REQ-017 hazard check only when macro PEM_DISPATCH_HAZARD_CHECK_EN is defined.
REQ-026 SHALL, without PEM_DISPATCH_HAZARD_CHECK_EN, remove the regid FIFO storage, keep only the counters and count limits, and tie hazard_stall to 0.

Verification
REQ-027 SHALL cover: load R3 accepted at cycle 0, pem_inst_rdy=1 -> pem_inst_vld=1 at cycle 1, ld_outstd=1 at cycle 2.
REQ-028 SHALL cover: load R5 outstanding, then store R5 -> hazard_stall=1, inst_rdy=0 until the cycle after pem_ld_ack; then the store issues (HAZARD_CHECK_EN).
REQ-029 SHALL cover: store R2 outstanding, then load R7 -> no stall, issues 1 cycle later.
REQ-030 SHALL cover: OUTSTD_DEPTH=4, five loads to distinct regs with no ack -> the 5th is held; one pem_ld_ack releases it, with ld_outstd back to 4.
REQ-031 SHALL cover: push and ack of a load in the same cycle -> ld_outstd unchanged; ld_ack pulses one cycle later.
REQ-032 SHALL cover: reset asserted with 2 loads outstanding and the output stage full -> all counts 0, pem_inst_vld=0 on the next cycle.
